// File: rtl/acc_flag_sequencer.sv
// Accumulator and Z/N/C/V flag sequencer wrapped around an external 8-bit add/sub unit.
// Define ACC_ADC_EN to turn opcode 000 into a two-pass add-with-carry (ADC) instead of NOP.
module acc_flag_sequencer #(
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] operand,
    output logic       busy,
    output logic       done,
    output logic [7:0] acc,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_c,
    output logic       flag_v,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_op,
    input  logic [7:0] add_s,
    input  logic       add_cout,
    input  logic       add_ovf
);

`ifdef ACC_ADC_EN
    localparam bit ADC_EN = 1'b1;
`else
    localparam bit ADC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_CMP = 3'b100,
        OP_INC = 3'b101,
        OP_DEC = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ISSUE2 = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e     state;
    state_e     state_nxt;
    op_e        op_q;
    logic [7:0] operand_q;
    logic       start_adder;
    logic       is_adc;

    // First-pass results held across ISSUE2 for the ADC carry/overflow merge.
    logic [7:0] s1;
    logic       c1;
    logic       a7;
    logic       b7;

    assign is_adc = ADC_EN && (op_q == OP_NOP);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_comb begin
        // NOTE: default first so no path leaves the output unassigned (no latch).
        start_adder = 1'b0;
        case (op_e'(opcode))
            OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: start_adder = 1'b1;
            OP_NOP:                                 start_adder = ADC_EN;
            default:                                start_adder = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = start_adder ? ISSUE : DONE;
            ISSUE:   state_nxt = is_adc ? ISSUE2 : DONE;
            ISSUE2:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_a  = acc;
        add_b  = 8'h00;
        add_op = 1'b0;
        if (state == ISSUE) begin
            case (op_q)
                OP_ADD: add_b = operand_q;
                OP_SUB,
                OP_CMP: begin
                    add_b  = operand_q;
                    add_op = 1'b1;
                end
                OP_INC: add_b = 8'h01;
                OP_DEC: begin
                    add_b  = 8'h01;
                    add_op = 1'b1;
                end
                OP_NOP: if (ADC_EN) add_b = operand_q;
                default: ;
            endcase
        end else if (ADC_EN && state == ISSUE2) begin
            // Second ADC pass folds the old carry into the first-pass sum.
            add_a = s1;
            add_b = {7'b0, flag_c};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= ACC_RESET;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            op_q      <= OP_NOP;
            operand_q <= 8'h00;
            s1        <= 8'h00;
            c1        <= 1'b0;
            a7        <= 1'b0;
            b7        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op_e'(opcode);
                        operand_q <= operand;
                        if (op_e'(opcode) == OP_LDA) begin
                            acc    <= operand;
                            flag_z <= (operand == 8'h00);
                            flag_n <= operand[7];
                        end else if (op_e'(opcode) == OP_CLR) begin
                            acc    <= 8'h00;
                            flag_z <= 1'b1;
                            flag_n <= 1'b0;
                            flag_c <= 1'b0;
                            flag_v <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (is_adc) begin
                        s1 <= add_s;
                        c1 <= add_cout;
                        a7 <= acc[7];
                        b7 <= operand_q[7];
                    end else begin
                        if (op_q != OP_CMP) acc <= add_s;
                        flag_z <= (add_s == 8'h00);
                        flag_n <= add_s[7];
                        flag_c <= add_cout;
                        flag_v <= add_ovf;
                    end
                end
                ISSUE2: begin
                    if (ADC_EN) begin
                        acc    <= add_s;
                        flag_z <= (add_s == 8'h00);
                        flag_n <= add_s[7];
                        flag_c <= c1 | add_cout;
                        flag_v <= (a7 == b7) && (add_s[7] != a7);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
